fpu_add_arbiter: RTL
====================

# fpu_add_arbiter

Shares one combinational half-precision adder (`adder_fpu`) between up to `NUM_REQ` requesters, such as pipeline execute lanes and the crypto core.
- Arbitrates round-robin.
- Registers the winner's operands and drives the adder for one cycle.
- Captures the result and overflow flag.
- Holds the response to the owning requester until that requester accepts it.
- One operation is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (legal 2..8); `IDX_W = $clog2(NUM_REQ)` is derived.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_a`  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- `req_b`  in  16*NUM_REQ  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  grant, one-hot or zero; request accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  result available to the owner, one-hot or zero.
- `rsp_res`  out  16  result value.
- `rsp_overflow`  out  1  overflow/exception flag from the adder.
- `rsp_ready`  in  NUM_REQ  requester accepts the response.
- `fpu_a`, `fpu_b`  out  16  operands driven to the adder.
- `fpu_vld`  out  1  adder input valid.
- `fpu_res`  in  16  adder result.
- `fpu_res_vld`  in  1  adder result valid.
- `fpu_overflow`  in  1  adder overflow.
- `busy`  out  1  high whenever the state is not IDLE.
- `ops_done`  out  16  completed-operation counter; wraps 0xFFFF -> 0x0000.

## Operation
- FSM has three states: IDLE, EXEC, RESP.

IDLE:
- If any `req_valid` bit is set, the winner g is the first set bit searching upward (cyclically) from `ptr+1`.
- `req_ready[g]` is asserted combinationally in the same cycle; it is the only `req_ready` bit ever high.
- On that edge: `op_a <= req_a[g]`, `op_b <= req_b[g]`, `owner <= g`, `ptr <= g`, next state EXEC.
- If no `req_valid` bit is set, stay in IDLE; `ptr` is unchanged.

EXEC:
- `fpu_vld = 1`.
- On the edge, capture `res_q <= fpu_res` and `ovf_q <= fpu_overflow`; next state RESP.
- If `fpu_res_vld` is 0 in EXEC, the arbiter captures `res_q = 0x7E00` and `ovf_q = 1`, and still goes to RESP.

RESP:
- `rsp_valid[owner] = 1`; `rsp_res = res_q`; `rsp_overflow = ovf_q`.
- When `rsp_ready[owner]` is high: next state IDLE and `ops_done` increments.
- `rsp_ready` bits of non-owners are ignored.

Output rules:
- `fpu_a`/`fpu_b` always equal `op_a`/`op_b`.
- `fpu_vld` is 0 in every state except EXEC.
- `rsp_res`/`rsp_overflow` always show `res_q`/`ovf_q`; they are meaningful only while `rsp_valid` is high.
- `req_ready` is all-zero outside IDLE.

Other behaviour:
- A requester may drop `req_valid` before being granted; arbitration re-evaluates every cycle and has no sticky grant.
- A requester may raise a new `req_valid` while its own response is pending; it is considered only at the next IDLE.
- After granting g, requester g has the lowest priority next round. This gives starvation freedom: any continuously-asserted request is granted within `NUM_REQ` operations.

## Timing
- Reset values: state IDLE, `ptr = NUM_REQ-1` (so requester 0 wins first after reset), `op_a = op_b = res_q = 0`, `ovf_q = 0`, `owner = 0`, `ops_done = 0`, `busy = 0`.
- Immediately after reset, all outputs are 0.
- Latency: accept at edge T (IDLE) -> `fpu_vld` high during cycle T+1 -> `rsp_valid` high from cycle T+2.
- Minimum issue interval is 3 cycles, reached when `rsp_ready` is high in the first RESP cycle. The next grant occurs in the IDLE cycle after.
- Backpressure: RESP holds indefinitely; `rsp_res` is stable and `req_ready` stays 0.
- Reset asserted in any state: the in-flight operation is discarded with no response. Outputs clear asynchronously; nothing is re-issued.
- Simultaneous requests: exactly one grant per IDLE cycle.
- `ops_done` increments only on the RESP handshake edge.

## Test plan
- Single requester 1 issues A=0x3C00, B=0x3C00 (1.0+1.0): `req_ready[1]` at T, `fpu_vld` at T+1, `rsp_valid=4'b0010` and `rsp_res=0x4000`, `rsp_overflow=0` at T+2. `ops_done=1` after accept.
- All four requesters continuously valid with `rsp_ready` tied high: grant order 0,1,2,3,0,1 with a 3-cycle interval. Each response goes only to its owner.
- Requester 2 issues 0x7C00 + 0xFC00 (+inf + -inf): `rsp_res=0x7E00`, `rsp_overflow=1`.
- Hold `rsp_ready[0]` low for 5 cycles after the result of 0x3C00+0x4000: `rsp_valid[0]` and `rsp_res=0x4200` stay stable and `req_ready` stays 0. Requester 3's pending request is granted in the IDLE cycle after the handshake. Asserting `rsp_ready[3]` during the stall has no effect.
- Assert `rst` for 1 cycle while in EXEC: no `rsp_valid` pulse, `busy=0`, `ops_done` unchanged at 0. The next grant goes to requester 0.
- Force `ops_done` to 0xFFFF via 65535 ops (or a backdoor preload), then complete one more: `ops_done` reads 0x0000.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one combinational half-precision adder between
// NUM_REQ requesters; one operation in flight, response held until accepted.
module fpu_add_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_res,
  output logic                  rsp_overflow,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [15:0]           fpu_a,
  output logic [15:0]           fpu_b,
  output logic                  fpu_vld,
  input  logic [15:0]           fpu_res,
  input  logic                  fpu_res_vld,
  input  logic                  fpu_overflow,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] NAN_RES = 16'h7E00;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [15:0]      res_q;
  logic             ovf_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

  // First pending requester searching upward from ptr+1, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_ready    = (state == IDLE && grant_found && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid    = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign rsp_res      = res_q;
  assign rsp_overflow = ovf_q;
  assign fpu_a        = op_a;
  assign fpu_b        = op_b;
  assign fpu_vld      = (state == EXEC);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a  <= req_a[32'(grant_idx)*16 +: 16];
            op_b  <= req_b[32'(grant_idx)*16 +: 16];
            owner <= grant_idx;
            ptr   <= grant_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          // A missing result valid is reported as a quiet NaN with the exception flag
          if (fpu_res_vld) begin
            res_q <= fpu_res;
            ovf_q <= fpu_overflow;
          end else begin
            res_q <= NAN_RES;
            ovf_q <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            state    <= IDLE;
            ops_done <= ops_done + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
